// File: rtl/barrel_cmd_seq.sv
// barrel_cmd_seq: command FIFO + sequencer driving an 8-bit barrel rotator.
// Each command is either a single rotate step or a sweep over every sel value.
// sample_stb/sample_sel follow Load/sel by LAT cycles, so downstream logic
// knows when the rotator's data_out is valid and which amount it belongs to.
// Optional build macro: BARREL_CMD_SEQ_STATS_EN adds the cmd_done_cnt output.
module barrel_cmd_seq #(
   parameter int DATA_W     = 8,
   parameter int SEL_W      = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int LAT        = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_rot,
   input  logic              in_sweep,
   output logic              Load,
   output logic [SEL_W-1:0]  sel,
   output logic [DATA_W-1:0] data_in,
   output logic              sample_stb,
   output logic [SEL_W-1:0]  sample_sel,
   output logic              busy
`ifdef BARREL_CMD_SEQ_STATS_EN
   ,
   output logic [15:0]       cmd_done_cnt
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + SEL_W + DATA_W;

   typedef enum logic {IDLE, APPLY} state_t;

   state_t            state, state_nxt;
   logic [EW-1:0]     mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              full, empty, push, pop, done;
   logic              cur_sweep;
   logic [SEL_W-1:0]  cur_rot;
   logic [DATA_W-1:0] cur_data;
   logic [SEL_W:0]    k, k_nxt, k_inc;
   logic              load_nxt;
   logic [SEL_W-1:0]  sel_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic [LAT-1:0]    vld_pipe;
   logic [SEL_W-1:0]  sel_pipe [LAT];

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign busy     = (state != IDLE) || !empty;
   assign k_inc    = k + 1'b1;

   // FIFO storage; contents need no reset since the pointers gate validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {in_sweep, in_rot, in_data};
   end

   // FIFO pointers and the latched command popped by the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cur_sweep <= 1'b0;
         cur_rot   <= '0;
         cur_data  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr                         <= rd_ptr + 1'b1;
            {cur_sweep, cur_rot, cur_data} <= mem[rd_ptr[AW-1:0]];
         end
      end
   end

   // Next state and next rotator drive; sel/data_in hold while idle.
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      k_nxt     = k;
      load_nxt  = 1'b0;
      sel_nxt   = sel;
      data_nxt  = data_in;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               k_nxt     = '0;
               state_nxt = APPLY;
            end
         end
         APPLY: begin
            load_nxt = 1'b1;
            data_nxt = cur_data;
            if (cur_sweep) begin
               sel_nxt = k[SEL_W-1:0];
               k_nxt   = k_inc;
               if (k_inc[SEL_W]) begin
                  state_nxt = IDLE;
                  done      = 1'b1;
               end
            end else begin
               sel_nxt   = cur_rot;
               state_nxt = IDLE;
               done      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus registered rotator outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         k       <= '0;
         Load    <= 1'b0;
         sel     <= '0;
         data_in <= '0;
      end else begin
         state   <= state_nxt;
         k       <= k_nxt;
         Load    <= load_nxt;
         sel     <= sel_nxt;
         data_in <= data_nxt;
      end
   end

   // Delay Load/sel by the rotator latency to form the sample strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         for (int i = 0; i < LAT; i++) sel_pipe[i] <= '0;
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            vld_pipe[i] <= vld_pipe[i-1];
            sel_pipe[i] <= sel_pipe[i-1];
         end
         vld_pipe[0] <= Load;
         sel_pipe[0] <= sel;
      end
   end

   assign sample_stb = vld_pipe[LAT-1];
   assign sample_sel = sel_pipe[LAT-1];

`ifdef BARREL_CMD_SEQ_STATS_EN
   // Completed-command counter, bumped on each command's final APPLY cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              cmd_done_cnt <= '0;
      else if (done && cmd_done_cnt != 16'hFFFF) cmd_done_cnt <= cmd_done_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_barrel_cmd_seq.sv
// tb_barrel_cmd_seq: directed bench for barrel_cmd_seq. A queue of expected
// rotator beats (built from each accepted command) is checked every cycle,
// alongside literal expectations for latency, backpressure and reset abort.
module tb_barrel_cmd_seq;
   localparam int LAT = 1;

   typedef struct {
      logic [2:0] sel;
      logic [7:0] data;
      logic [7:0] rot;
      bit         first;
      bit         last;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic [2:0] in_rot = '0;
   logic       in_sweep = 1'b0;
   logic       Load;
   logic [2:0] sel;
   logic [7:0] data_in;
   logic       sample_stb;
   logic [2:0] sample_sel;
   logic       busy;
`ifdef BARREL_CMD_SEQ_STATS_EN
   logic [15:0] cmd_done_cnt;
   int          done_model = 0;
`endif

   int    checks = 0;
   int    errors = 0;
   beat_t exp_q[$];
   logic  ld_h [LAT];
   logic [2:0] sel_h [LAT];
   logic  prev_load = 1'b0;

   barrel_cmd_seq dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_rot(in_rot), .in_sweep(in_sweep),
      .Load(Load), .sel(sel), .data_in(data_in),
      .sample_stb(sample_stb), .sample_sel(sample_sel), .busy(busy)
`ifdef BARREL_CMD_SEQ_STATS_EN
      , .cmd_done_cnt(cmd_done_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Rotate-right by s: output bit i takes input bit (i+s) mod 8.
   function automatic logic [7:0] rot_model(input logic [7:0] d, input int s);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = d[(i + s) % 8];
      return r;
   endfunction

   task automatic chk(input bit ok, input string name, input int act, input int expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   // Drive one command; returns just after the accepting edge.
   task automatic push(input bit sw, input int rot, input logic [7:0] d, output int waits);
      @(negedge clk);
      in_valid = 1'b1; in_sweep = sw; in_rot = rot[2:0]; in_data = d;
      waits = 0;
      while (!in_ready && waits < 100) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 100) chk(1'b0, "push_timeout", waits, 0);
      @(posedge clk);
      if (sw) begin
         for (int s = 0; s < 8; s++)
            exp_q.push_back('{sel: s[2:0], data: d, rot: rot_model(d, s), first: (s == 0), last: (s == 7)});
      end else begin
         exp_q.push_back('{sel: rot[2:0], data: d, rot: rot_model(d, rot), first: 1'b1, last: 1'b1});
      end
      #1;
      in_valid = 1'b0;
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((busy || Load) && n < 200) begin
         cyc(1);
         n++;
      end
      chk(n < 200, name, n, 0);
   endtask

   // Per-cycle compare against the beat queue and delayed Load/sel history.
   always @(posedge clk) begin
      beat_t b;
      #1;
      if (reset) begin
         for (int i = 0; i < LAT; i++) begin ld_h[i] = 1'b0; sel_h[i] = '0; end
         prev_load = 1'b0;
      end else begin
         chk(sample_stb == ld_h[LAT-1], "sample_stb", sample_stb, ld_h[LAT-1]);
         if (sample_stb) chk(sample_sel == sel_h[LAT-1], "sample_sel", sample_sel, sel_h[LAT-1]);
         if (Load) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_load", sel, 0);
            end else begin
               b = exp_q.pop_front();
               chk(sel == b.sel, "beat_sel", sel, b.sel);
               chk(data_in == b.data, "beat_data", data_in, b.data);
               chk(rot_model(data_in, sel) == b.rot, "beat_rot", rot_model(data_in, sel), b.rot);
               if (b.first) chk(!prev_load, "idle_gap", prev_load, 0);
`ifdef BARREL_CMD_SEQ_STATS_EN
               if (b.last) done_model++;
`endif
            end
         end
         chk(busy == (exp_q.size() != 0), "busy", busy, exp_q.size() != 0);
`ifdef BARREL_CMD_SEQ_STATS_EN
         chk(cmd_done_cnt == done_model[15:0], "cmd_done_cnt", cmd_done_cnt, done_model);
`endif
         for (int i = LAT - 1; i > 0; i--) begin ld_h[i] = ld_h[i-1]; sel_h[i] = sel_h[i-1]; end
         ld_h[0]   = Load;
         sel_h[0]  = sel;
         prev_load = Load;
      end
   end

   initial begin
      logic [7:0] lit [8];
      int w, n, loads;
      lit = '{8'h81, 8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03};

      // Reset values
      cyc(3);
      chk(Load == 0 && sel == 0 && data_in == 0, "rst_drive", {Load, sel, data_in}, 0);
      chk(sample_stb == 0 && sample_sel == 0 && busy == 0, "rst_stb", {sample_stb, sample_sel, busy}, 0);
      @(negedge clk); reset = 1'b0;
      #1;
      chk(in_ready == 1, "rst_in_ready", in_ready, 1);

      // Single rotate: pop at E1, Load visible from E2, strobe LAT later
      chk(rot_model(8'hB4, 3) == 8'h96, "model_B4", rot_model(8'hB4, 3), 8'h96);
      push(1'b0, 3, 8'hB4, w);
      cyc(1);
      chk(Load == 0, "single_E1_load", Load, 0);
      cyc(1);
      chk(Load == 1 && sel == 3 && data_in == 8'hB4, "single_E2", {Load, sel, data_in}, {1'b1, 3'd3, 8'hB4});
      chk(rot_model(data_in, sel) == 8'h96, "single_out", rot_model(data_in, sel), 8'h96);
      cyc(1);
      chk(Load == 0, "single_E3_load", Load, 0);
      chk(sample_stb == 1 && sample_sel == 3, "single_stb", {sample_stb, sample_sel}, {1'b1, 3'd3});
      cyc(3);

      // Sweep of 0x81
      for (int s = 0; s < 8; s++) chk(rot_model(8'h81, s) == lit[s], "model_sweep", rot_model(8'h81, s), lit[s]);
      push(1'b1, 0, 8'h81, w);
      n = 0;
      while (!Load && n < 20) begin cyc(1); n++; end
      chk(n < 20, "sweep_start", n, 0);
      for (int s = 0; s < 8; s++) begin
         if (s > 0) cyc(1);
         chk(Load == 1 && sel == s[2:0], "sweep_sel", {Load, sel}, {1'b1, s[2:0]});
         chk(rot_model(data_in, sel) == lit[s], "sweep_out", rot_model(data_in, sel), lit[s]);
      end
      cyc(1);
      chk(Load == 0 && busy == 0, "sweep_end", {Load, busy}, 0);
`ifdef BARREL_CMD_SEQ_STATS_EN
      chk(cmd_done_cnt == 16'd2, "stats_two", cmd_done_cnt, 2);
`endif

      // Idle hold
      cyc(10);
      chk(Load == 0 && busy == 0 && sample_stb == 0, "idle_quiet", {Load, busy, sample_stb}, 0);
      chk(sel == 3'd7 && data_in == 8'h81, "idle_hold", {sel, data_in}, {3'd7, 8'h81});

      // Backpressure: sweep then 4 back-to-back singles fill the FIFO
      push(1'b1, 0, 8'h5A, w);
      push(1'b0, 1, 8'h11, w);
      push(1'b0, 2, 8'h22, w);
      push(1'b0, 5, 8'h33, w);
      push(1'b0, 7, 8'hC3, w);
      chk(in_ready == 0, "full_not_ready", in_ready, 0);
      push(1'b0, 4, 8'hF0, w);
      chk(w > 0, "sixth_held", w, 1);
      wait_idle("fill_drain");
      chk(exp_q.size() == 0, "fill_all_done", exp_q.size(), 0);

      // Reset mid-sweep at k=4 with two commands queued
      push(1'b1, 0, 8'h3C, w);
      push(1'b0, 2, 8'h44, w);
      push(1'b0, 6, 8'h55, w);
      n = 0;
      while (!(Load && sel == 3'd4) && n < 40) begin cyc(1); n++; end
      chk(n < 40, "reach_k4", n, 0);
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
`ifdef BARREL_CMD_SEQ_STATS_EN
      done_model = 0;
`endif
      #1;
      chk(Load == 0 && sel == 0 && data_in == 0 && sample_stb == 0, "abort_outputs",
          {Load, sel, data_in, sample_stb}, 0);
`ifdef BARREL_CMD_SEQ_STATS_EN
      chk(cmd_done_cnt == 0, "stats_reset", cmd_done_cnt, 0);
`endif
      cyc(2);
      @(negedge clk); reset = 1'b0;
      #1;
      chk(in_ready == 1 && busy == 0, "abort_ready", {in_ready, busy}, 2);
      loads = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1);
         if (Load || sample_stb) loads++;
      end
      chk(loads == 0, "abort_no_exec", loads, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
